// File: rtl/bram_port_arbiter.sv
// Round-robin sequencer sharing one 512-bit BRAM port between a line reader,
// a 32-bit lane reader and a 32-bit lane-masked writer, one transaction at a time.
module bram_port_arbiter #(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 13
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_rd512_addr_ready,
  input  logic [ADDR_W-5:0] i_rd512_addr,
  output logic              o_rd512_data_valid,
  output logic [511:0]      o_rd512_data,
  input  logic              i_rd32_addr_ready,
  input  logic [ADDR_W-1:0] i_rd32_addr,
  output logic              o_rd32_data_valid,
  output logic [31:0]       o_rd32_data,
  input  logic              i_wr32_trig,
  input  logic [ADDR_W-1:0] i_wr32_addr,
  input  logic [31:0]       i_wr32_data,
  output logic              o_wr32_ack,
  output logic              o_bram_en,
  output logic [15:0]       o_bram_we,
  output logic [ADDR_W-5:0] o_bram_addr,
  output logic [511:0]      o_bram_wdata,
  input  logic [511:0]      i_bram_rdata,
  output logic              o_busy
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [1:0] G_RD512 = 2'd0;
  localparam logic [1:0] G_RD32  = 2'd1;
  localparam logic [1:0] G_WR32  = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [1:0]       rr_ptr;
  logic [1:0]       gnt;
  logic [1:0]       pick;
  logic [2:0]       req;
  logic [CNT_W-1:0] lat_cnt;
  logic [3:0]       lane_p0;

  // First requester found scanning upward (mod 3) from the pointer.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] sel;
    logic       found;
    int         idx;
    sel   = p;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idx = (int'(p) + i) % 3;
      if (!found && r[idx]) begin
        sel   = 2'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign req  = {i_wr32_trig, i_rd32_addr_ready, i_rd512_addr_ready};
  assign pick = rr_pick(req, rr_ptr);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state              <= IDLE;
      rr_ptr             <= G_RD512;
      gnt                <= G_RD512;
      lat_cnt            <= '0;
      o_rd512_data_valid <= 1'b0;
      o_rd512_data       <= '0;
      o_rd32_data_valid  <= 1'b0;
      o_rd32_data        <= '0;
      o_wr32_ack         <= 1'b0;
      o_bram_en          <= 1'b0;
      o_bram_we          <= '0;
      o_bram_addr        <= '0;
      o_bram_wdata       <= '0;
      o_busy             <= 1'b0;
    end else begin
      o_rd512_data_valid <= 1'b0;
      o_rd32_data_valid  <= 1'b0;
      o_wr32_ack         <= 1'b0;
      o_bram_en          <= 1'b0;
      o_bram_we          <= '0;
      case (state)
        // IDLE -> ISSUE: grant, latch request fields straight into the port registers
        IDLE: begin
          if (|req) begin
            gnt       <= pick;
            rr_ptr    <= (pick == G_WR32) ? G_RD512 : pick + 2'd1;
            state     <= ISSUE;
            o_busy    <= 1'b1;
            o_bram_en <= 1'b1;
            case (pick)
              G_RD512: o_bram_addr <= i_rd512_addr;
              G_RD32:  o_bram_addr <= i_rd32_addr[ADDR_W-1:4];
              default: begin
                o_bram_addr  <= i_wr32_addr[ADDR_W-1:4];
                o_bram_we    <= 16'h0001 << i_wr32_addr[3:0];
                o_bram_wdata <= {16{i_wr32_data}};
              end
            endcase
          end
        end
        // ISSUE -> WAIT (read) or RESP (write, already committed at this edge)
        ISSUE: begin
          if (gnt == G_WR32) begin
            state      <= RESP;
            o_wr32_ack <= 1'b1;
          end else begin
            state   <= WAIT;
            lat_cnt <= CNT_W'(RD_LAT - 1);
          end
        end
        // WAIT -> RESP: read data lands when the latency counter expires
        WAIT: begin
          if (lat_cnt == '0) begin
            state <= RESP;
            if (gnt == G_RD512) begin
              o_rd512_data       <= i_bram_rdata;
              o_rd512_data_valid <= 1'b1;
            end else begin
              o_rd32_data        <= i_bram_rdata[{lane_p0, 5'b0} +: 32];
              o_rd32_data_valid  <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        // RESP -> IDLE: response pulse is live during this cycle
        RESP: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Lane is only consumed by an rd32 grant, so it is captured every IDLE cycle.
  always_ff @(posedge i_clk) begin
    if (state == IDLE) lane_p0 <= i_rd32_addr[3:0];
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Sequences and shares the single 512-bit connected-domain BRAM port among three requesters: the 512-bit line reader, the 32-bit reader (`rd_32b_from_bram`) and the 32-bit masked writer (`wr_32b_to_bram`). It serves one transaction at a time, chosen by round-robin, and handles 32-bit lane selection and lane write enables. It sits between the line-boundary-search datapath and the BRAM primitive.

## Interface
Parameters:
- RD_LAT, 2, BRAM read latency in cycles from the enable cycle to valid `i_bram_rdata`; must be at least 1.
- ADDR_W, 13, 32-bit word address width. The line address is `ADDR_W-4` bits and the lane is `addr[3:0]`.

Ports (clock and reset first):
- i_clk  in  1  single clock.
- i_rstn  in  1  asynchronous, active-low reset.
- i_rd512_addr_ready  in  1  512-bit read request; level, held until response.
- i_rd512_addr  in  ADDR_W-4  line address.
- o_rd512_data_valid  out  1  one-cycle response pulse.
- o_rd512_data  out  512  read line.
- i_rd32_addr_ready  in  1  32-bit read request; level, held until response.
- i_rd32_addr  in  ADDR_W  word address.
- o_rd32_data_valid  out  1  one-cycle response pulse.
- o_rd32_data  out  32  selected lane.
- i_wr32_trig  in  1  32-bit write request; level, held until ack.
- i_wr32_addr  in  ADDR_W  word address.
- i_wr32_data  in  32  write data.
- o_wr32_ack  out  1  one-cycle completion pulse.
- o_bram_en  out  1  BRAM enable.
- o_bram_we  out  16  lane write enables.
- o_bram_addr  out  ADDR_W-4  BRAM line address.
- o_bram_wdata  out  512  write data.
- i_bram_rdata  in  512  BRAM read data.
- o_busy  out  1  high whenever the FSM is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Requests are sampled only in IDLE.
- **IDLE:** if any request is high, grant one requester using the round-robin pointer, register its address, lane and data, then go to ISSUE. Otherwise stay in IDLE.
- **Round-robin:** priority order starts at the pointer (0 = rd512, 1 = rd32, 2 = wr32). After a grant to k, the pointer becomes (k+1) mod 3. The reset pointer is 0.
- **ISSUE:** for one cycle, `o_bram_en`=1 and `o_bram_addr` = the registered line address.
  - Read: `o_bram_we`=0, then go to WAIT with the latency counter loaded to RD_LAT-1.
  - Write: `o_bram_we` = 16'b1 << lane and `o_bram_wdata` = {16{data}}, then go directly to RESP.
- **WAIT:** the counter decrements each cycle. At 0, capture `i_bram_rdata` into the response register and go to RESP.
- **RESP:** pulse for one cycle the response of the granted requester only:
  - rd512: `o_rd512_data_valid`, with `o_rd512_data` = the captured line.
  - rd32: `o_rd32_data_valid`, with `o_rd32_data` = captured[lane*32 +: 32].
  - wr32: `o_wr32_ack`.
  - Then go to IDLE.
- **Data outputs:** `o_rd512_data` and `o_rd32_data` are registered and hold their value until the next response of the same kind.
- **Requester obligation:** drop the request by the cycle after its response pulse. A request still high in IDLE is treated as a new transaction.
- **Stability:** address and data may change after grant. The arbiter uses only the values latched in the IDLE grant cycle.
- **Reset:** asserting reset in any state aborts the in-flight transaction. No response is issued. All state returns to reset values immediately.
- **Reset values:** all outputs are 0, including `o_bram_we` and both data buses. The FSM is in IDLE and the pointer is 0.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Request high in IDLE at cycle N → `o_bram_en`=1 at N+1.
- Read response pulse at N+2+RD_LAT. For RD_LAT=2, that is N+4.
- Write ack at N+2, with the BRAM write performed at the N+1 edge.
- Back-to-back: the next grant is evaluated at the cycle after RESP.
  - Read transaction period: RD_LAT+3 cycles.
  - Write transaction period: 3 cycles.
- Worst-case wait for a held request: two other transactions, bounded by round-robin.
- Simultaneous requests in IDLE: exactly one grant per IDLE cycle. The others stay pending and are never dropped.

## Test plan
- **Single rd512**, addr 9'h005, BRAM line 5 = pattern P, RD_LAT=2 → `o_bram_en` one cycle with addr 5, `o_bram_we`=0; `o_rd512_data_valid` pulse at N+4 with data P.
- **Single rd32** at addr 13'h0057 → line 5, lane 7; `o_rd32_data` = P[255:224] at N+4; no pulse on the other responses.
- **wr32** at addr 13'h0052 with data 32'hDEADBEEF → at N+1, `o_bram_we`=16'h0004 and line 5; ack at N+2; a following rd32 of 13'h0052 returns DEADBEEF.
- **All three requests high from reset, held until served** → grant order rd512, rd32, wr32; a second round with all three high again keeps the order rd512, rd32, wr32.
- **rd32 held continuously high with wr32 also high** → the grants alternate rd32 and wr32; neither requester is starved.
- **Reset asserted during WAIT of rd512** → no `o_rd512_data_valid`; all outputs are 0 while reset is low; after release, the pointer is 0 and a new request is served normally.
